// File: rtl/tb_pkg.sv
// Shared harness types for the run supervisor.
//   run_state_e  : supervisor phase (idle, running, draining, done)
//   run_result_e : final classification of a run
package tb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } run_state_e;

   typedef enum logic [2:0] {
      RES_NONE,
      RES_PASS,
      RES_FAIL,
      RES_TIMEOUT,
      RES_HANG
   } run_result_e;

endpackage

// File: rtl/tb_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
//   clk    : clock
//   rst_n  : async active-low reset, clears the count
//   clr    : synchronous clear to zero
//   inc    : increment by one, holding at all-ones
//   q      : current count
module tb_sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/tb_run_monitor.sv
// Harness-side run supervisor. Times the run against a cycle budget, watches for DUT
// completion and for loss of progress, classifies the outcome and then drains for a fixed
// number of cycles before raising finish_req.
//   clk, rst_n   : clock, async active-low reset
//   max_cycles   : cycle budget (0 = unlimited), captured when start is accepted
//   start        : begin supervision (only honoured in ST_IDLE)
//   progress     : DUT activity strobe, clears the hang counter
//   test_done    : DUT end-of-test, qualified by test_pass
//   cycle_count  : cycles spent in ST_RUN, saturating
//   state        : current run_state_e
//   result       : run_result_e classification, frozen once set
//   finish_req   : level, high from one cycle after entering ST_DONE until reset
module tb_run_monitor
   import tb_pkg::*;
#(
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned DRAIN_CYCLES = 16,
   parameter int unsigned HANG_LIMIT   = 100000,
   parameter bit          HANG_EN      = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] max_cycles,
   input  logic             start,
   input  logic             progress,
   input  logic             test_done,
   input  logic             test_pass,
   output logic [CNT_W-1:0] cycle_count,
   output run_state_e       state,
   output run_result_e      result,
   output logic             finish_req
);

   localparam int unsigned    DrainW    = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] HangLimit = CNT_W'(HANG_LIMIT);
   localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

   run_state_e        state_q, state_d;
   run_result_e       result_q, result_d;
   logic [DrainW-1:0] drain_q, drain_d;
   logic [CNT_W-1:0]  max_lat_q, max_lat_d;
   logic              finish_q, finish_d;

   logic              cc_clr, cc_inc, idle_clr, idle_inc;
   logic [CNT_W-1:0]  cc, idle_cnt;
   logic              end_run;

   tb_sat_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cc_clr),
      .inc   (cc_inc),
      .q     (cc)
   );

   tb_sat_counter #(.W(CNT_W)) u_idle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (idle_clr),
      .inc   (idle_inc),
      .q     (idle_cnt)
   );

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      drain_d   = drain_q;
      max_lat_d = max_lat_q;
      finish_d  = finish_q;
      cc_clr    = 1'b0;
      cc_inc    = 1'b0;
      idle_clr  = 1'b0;
      idle_inc  = 1'b0;
      end_run   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               max_lat_d = max_cycles;
               cc_clr    = 1'b1;
               idle_clr  = 1'b1;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            cc_inc   = 1'b1;
            idle_clr = progress;
            idle_inc = !progress;
            // Priority: done beats budget expiry beats hang.
            if (test_done) begin
               result_d = test_pass ? RES_PASS : RES_FAIL;
               end_run  = 1'b1;
            end else if ((max_lat_q != '0) && ((cc + 1'b1) == max_lat_q)) begin
               result_d = RES_TIMEOUT;
               end_run  = 1'b1;
            end else if (HANG_EN && ((idle_cnt + 1'b1) == HangLimit) && !progress) begin
               result_d = RES_HANG;
               end_run  = 1'b1;
            end
            if (end_run) begin
               state_d = ST_DRAIN;
               drain_d = '0;
            end
         end
         ST_DRAIN: begin
            if (drain_q == DrainLast) begin
               state_d = ST_DONE;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         ST_DONE: begin
            finish_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         result_q  <= RES_NONE;
         drain_q   <= '0;
         max_lat_q <= '0;
         finish_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         drain_q   <= drain_d;
         max_lat_q <= max_lat_d;
         finish_q  <= finish_d;
      end
   end

   assign cycle_count = cc;
   assign state       = state_q;
   assign result      = result_q;
   assign finish_req  = finish_q;

endmodule

// File: tb/tb_tb_run_monitor.sv
// Directed self-checking bench for tb_run_monitor (HANG_LIMIT=20, DRAIN_CYCLES=4).
module tb_tb_run_monitor;
   import tb_pkg::*;

   localparam int unsigned CntW  = 32;
   localparam int unsigned Drain = 4;

   logic            clk;
   logic            rst_n;
   logic [CntW-1:0] max_cycles;
   logic            start, progress, test_done, test_pass;
   logic [CntW-1:0] cycle_count;
   run_state_e      state;
   run_result_e     result;
   logic            finish_req;

   int checks = 0;
   int errors = 0;

   tb_run_monitor #(
      .CNT_W        (CntW),
      .DRAIN_CYCLES (Drain),
      .HANG_LIMIT   (20),
      .HANG_EN      (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .max_cycles  (max_cycles),
      .start       (start),
      .progress    (progress),
      .test_done   (test_done),
      .test_pass   (test_pass),
      .cycle_count (cycle_count),
      .state       (state),
      .result      (result),
      .finish_req  (finish_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges; inputs change and outputs are sampled 1ns after each edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; progress = 1'b0; test_done = 1'b0; test_pass = 1'b0;
      max_cycles = '0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic do_start(input logic [CntW-1:0] m);
      max_cycles = m;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (state !== ST_IDLE || result !== RES_NONE || cycle_count !== 0 || finish_req !== 1'b0) begin
         errors++;
         $display("FAIL reset: state=%0d result=%0d cc=%0d fin=%0b, want 0/0/0/0",
                  state, result, cycle_count, finish_req);
      end
   endtask

   task automatic test_pass_drain();
      do_reset();
      do_start(100);
      checks++;
      if (state !== ST_RUN || cycle_count !== 0) begin
         errors++;
         $display("FAIL start: state=%0d cc=%0d, want RUN/0", state, cycle_count);
      end
      progress = 1'b1;
      tick(39);
      test_done = 1'b1; test_pass = 1'b1;
      tick(1);
      test_done = 1'b0; test_pass = 1'b0;
      checks++;
      if (state !== ST_DRAIN || result !== RES_PASS || cycle_count !== 40) begin
         errors++;
         $display("FAIL pass_result: state=%0d result=%0d cc=%0d, want DRAIN/PASS/40",
                  state, result, cycle_count);
      end
      tick(Drain);
      checks++;
      if (state !== ST_DONE || finish_req !== 1'b0 || cycle_count !== 40) begin
         errors++;
         $display("FAIL pass_done_early: state=%0d fin=%0b cc=%0d, want DONE/0/40",
                  state, finish_req, cycle_count);
      end
      tick(1);
      checks++;
      if (finish_req !== 1'b1 || result !== RES_PASS) begin
         errors++;
         $display("FAIL pass_finish: fin=%0b result=%0d, want 1/PASS", finish_req, result);
      end
      // start in DONE is ignored
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(1);
      checks++;
      if (state !== ST_DONE || finish_req !== 1'b1 || cycle_count !== 40) begin
         errors++;
         $display("FAIL done_start_ignored: state=%0d fin=%0b cc=%0d, want DONE/1/40",
                  state, finish_req, cycle_count);
      end
      progress = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      do_start(50);
      progress = 1'b1;
      tick(49);
      checks++;
      if (state !== ST_RUN || cycle_count !== 49) begin
         errors++;
         $display("FAIL timeout_edge: state=%0d cc=%0d, want RUN/49", state, cycle_count);
      end
      tick(1);
      checks++;
      if (state !== ST_DRAIN || result !== RES_TIMEOUT || cycle_count !== 50) begin
         errors++;
         $display("FAIL timeout: state=%0d result=%0d cc=%0d, want DRAIN/TIMEOUT/50",
                  state, result, cycle_count);
      end
      // done in DRAIN is ignored
      test_done = 1'b1; test_pass = 1'b1;
      tick(2);
      test_done = 1'b0; test_pass = 1'b0;
      checks++;
      if (result !== RES_TIMEOUT || cycle_count !== 50 || state !== ST_DRAIN) begin
         errors++;
         $display("FAIL drain_frozen: state=%0d result=%0d cc=%0d, want DRAIN/TIMEOUT/50",
                  state, result, cycle_count);
      end
      progress = 1'b0;
   endtask

   task automatic test_done_priority();
      do_reset();
      do_start(50);
      progress = 1'b1;
      tick(49);
      test_done = 1'b1; test_pass = 1'b0;
      tick(1);
      test_done = 1'b0;
      checks++;
      if (result !== RES_FAIL || cycle_count !== 50 || state !== ST_DRAIN) begin
         errors++;
         $display("FAIL done_priority: state=%0d result=%0d cc=%0d, want DRAIN/FAIL/50",
                  state, result, cycle_count);
      end
      progress = 1'b0;
   endtask

   task automatic test_hang(input bool_variant);
      do_reset();
      do_start(0);
      progress = 1'b1;
      tick(10);
      progress = 1'b0;
      if (bool_variant) begin
         tick(14);
         progress = 1'b1;
         tick(1);
         progress = 1'b0;
      end
      tick(19);
      checks++;
      if (state !== ST_RUN || result !== RES_NONE) begin
         errors++;
         $display("FAIL hang_pre%0d: state=%0d result=%0d, want RUN/NONE",
                  bool_variant, state, result);
      end
      tick(1);
      checks++;
      if (state !== ST_DRAIN || result !== RES_HANG ||
          cycle_count !== (bool_variant ? 45 : 30)) begin
         errors++;
         $display("FAIL hang%0d: state=%0d result=%0d cc=%0d, want DRAIN/HANG/%0d",
                  bool_variant, state, result, cycle_count, bool_variant ? 45 : 30);
      end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      do_start(0);
      progress = 1'b1;
      tick(5);
      test_done = 1'b1; test_pass = 1'b1;
      tick(1);
      test_done = 1'b0;
      tick(1);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (state !== ST_IDLE || result !== RES_NONE || cycle_count !== 0 || finish_req !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: state=%0d result=%0d cc=%0d fin=%0b, want 0/0/0/0",
                  state, result, cycle_count, finish_req);
      end
      tick(1);
      rst_n = 1'b1;
      tick(1);
      do_start(100);
      tick(7);
      checks++;
      if (state !== ST_RUN || cycle_count !== 7 || result !== RES_NONE) begin
         errors++;
         $display("FAIL restart: state=%0d cc=%0d result=%0d, want RUN/7/NONE",
                  state, cycle_count, result);
      end
      progress = 1'b0;
   endtask

   task automatic test_ignored_inputs();
      do_reset();
      // done/progress in IDLE
      test_done = 1'b1; test_pass = 1'b1; progress = 1'b1;
      tick(3);
      test_done = 1'b0; test_pass = 1'b0;
      checks++;
      if (state !== ST_IDLE || result !== RES_NONE || cycle_count !== 0) begin
         errors++;
         $display("FAIL idle_ignore: state=%0d result=%0d cc=%0d, want IDLE/NONE/0",
                  state, result, cycle_count);
      end
      do_start(100);
      tick(5);
      // start in RUN must not restart the count
      start = 1'b1; max_cycles = 3;
      tick(1);
      start = 1'b0;
      tick(3);
      checks++;
      if (state !== ST_RUN || cycle_count !== 9 || result !== RES_NONE) begin
         errors++;
         $display("FAIL run_start_ignored: state=%0d cc=%0d result=%0d, want RUN/9/NONE",
                  state, cycle_count, result);
      end
      progress = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_pass_drain();
      test_timeout();
      test_done_priority();
      test_hang(1'b0);
      test_hang(1'b1);
      test_reset_mid_drain();
      test_ignored_inputs();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
